// File: rtl/axi_lite_reg_master.sv
// Single-outstanding AXI4-Lite register master: one command in, one response out,
// with a saturating per-transaction timeout and a drain phase that retires the bus after a timeout.
module axi_lite_reg_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int unsigned AW_W    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW_W    = C_M_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W  = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [AW_W-1:0]     addr_q, addr_d;
  logic [DW_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic                ar_pend_q, ar_pend_d;
  logic                b_out_q, b_out_d;
  logic                r_out_q, r_out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DW_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic busy, b_hs, r_hs, timeout_hit;
  logic aw_left, w_left, ar_left, b_left, r_left, any_left;

  // Channel handshakes and what remains outstanding after this cycle
  assign busy   = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_RESP);
  assign b_hs   = m_axi_bready & m_axi_bvalid;
  assign r_hs   = m_axi_rready & m_axi_rvalid;
  assign aw_left  = aw_pend_q & ~m_axi_awready;
  assign w_left   = w_pend_q & ~m_axi_wready;
  assign ar_left  = ar_pend_q & ~m_axi_arready;
  assign b_left   = b_out_q & ~b_hs;
  assign r_left   = r_out_q & ~r_hs;
  assign any_left = aw_left | w_left | ar_left | b_left | r_left;

  // A real B/R response in the limit cycle beats the timeout
  assign timeout_hit = TO_EN && busy && (cnt_q == TO_LIMIT) && !(b_hs || r_hs);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_pend_q     <= 1'b0;
      w_pend_q      <= 1'b0;
      ar_pend_q     <= 1'b0;
      b_out_q       <= 1'b0;
      r_out_q       <= 1'b0;
      cnt_q         <= '0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_pend_q     <= aw_pend_d;
      w_pend_q      <= w_pend_d;
      ar_pend_q     <= ar_pend_d;
      b_out_q       <= b_out_d;
      r_out_q       <= r_out_d;
      cnt_q         <= cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_pend_d     = aw_left;
    w_pend_d      = w_left;
    ar_pend_d     = ar_left;
    b_out_d       = b_left;
    r_out_d       = r_left;
    cnt_d         = (busy && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          cnt_d   = '0;
          if (cmd_write) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            b_out_d   = 1'b1;
            state_d   = WR_REQ;
          end else begin
            ar_pend_d = 1'b1;
            r_out_d   = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (!aw_left && !w_left) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi_bresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end
      end
      RD_REQ: begin
        if (!ar_left) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (r_hs) begin
          rsp_rdata_d   = m_axi_rdata;
          rsp_resp_d    = m_axi_rresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = any_left ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!any_left) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Timeout leaves the pending flags alone so DRAIN can finish the bus protocol
    if (timeout_hit) begin
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      state_d       = RSP;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RSP);
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = aw_pend_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = w_pend_q;
  assign m_axi_bready  = (state_q == WR_RESP) || ((state_q == DRAIN) && b_out_q);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = ar_pend_q;
  assign m_axi_rready  = (state_q == RD_RESP) || ((state_q == DRAIN) && r_out_q);

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Bench for axi_lite_reg_master: delay-programmable AXI-lite slave plus a cycle-level
// transaction model predicting response latency, content and return-to-idle cycle.
module tb_axi_lite_reg_master;

  localparam int unsigned TO = 16;
  localparam int TC = TO + 1;  // busy cycle in which the counter equals TO

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [31:0] m_axi_rdata = '0;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;

  axi_lite_reg_master #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave behaviour knobs for the current transaction
  int          ad = 0, wd = 0, bd = 0;
  logic [1:0]  s_resp = '0;
  logic [31:0] s_rdata = '0, exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;

  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit aw_done = 0, w_done = 0, b_arm = 0, r_arm = 0;
  bit aw_hs_q = 0, w_hs_q = 0, ar_hs_q = 0, b_hs_q = 0, r_hs_q = 0;
  bit aw_wait = 0, w_wait = 0, ar_wait = 0;

  // Slave: decisions made mid-cycle, handshakes land on the following rising edge
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_rvalid = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_done = 0; w_done = 0; b_arm = 0; r_arm = 0;
      aw_hs_q = 0; w_hs_q = 0; ar_hs_q = 0; b_hs_q = 0; r_hs_q = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
    end else begin
      if (aw_wait) check("awvalid_hold", m_axi_awvalid, 1'b1);
      if (w_wait)  check("wvalid_hold", m_axi_wvalid, 1'b1);
      if (ar_wait) check("arvalid_hold", m_axi_arvalid, 1'b1);
      if (aw_hs_q) begin check("awvalid_drop", m_axi_awvalid, 1'b0); aw_done = 1; aw_cnt = 0; end
      if (w_hs_q)  begin check("wvalid_drop", m_axi_wvalid, 1'b0); w_done = 1; w_cnt = 0; end
      if (ar_hs_q) begin check("arvalid_drop", m_axi_arvalid, 1'b0); ar_cnt = 0; r_arm = 1; r_cnt = 0; end
      if (b_hs_q) begin m_axi_bvalid = 0; b_arm = 0; end
      if (r_hs_q) begin m_axi_rvalid = 0; r_arm = 0; end
      if (aw_done && w_done) begin aw_done = 0; w_done = 0; b_arm = 1; b_cnt = 0; end
      if (b_arm && !m_axi_bvalid) begin
        if (b_cnt >= bd) begin m_axi_bvalid = 1; m_axi_bresp = s_resp; end
        else b_cnt++;
      end
      if (r_arm && !m_axi_rvalid) begin
        if (r_cnt >= bd) begin m_axi_rvalid = 1; m_axi_rresp = s_resp; m_axi_rdata = s_rdata; end
        else r_cnt++;
      end
      m_axi_awready = m_axi_awvalid && (aw_cnt >= ad);
      m_axi_wready  = m_axi_wvalid && (w_cnt >= wd);
      m_axi_arready = m_axi_arvalid && (ar_cnt >= ad);
      if (m_axi_awvalid && !m_axi_awready) aw_cnt++;
      if (m_axi_wvalid && !m_axi_wready) w_cnt++;
      if (m_axi_arvalid && !m_axi_arready) ar_cnt++;
      aw_hs_q = m_axi_awvalid && m_axi_awready;
      w_hs_q  = m_axi_wvalid && m_axi_wready;
      ar_hs_q = m_axi_arvalid && m_axi_arready;
      b_hs_q  = m_axi_bvalid && m_axi_bready;
      r_hs_q  = m_axi_rvalid && m_axi_rready;
      aw_wait = m_axi_awvalid && !m_axi_awready;
      w_wait  = m_axi_wvalid && !m_axi_wready;
      ar_wait = m_axi_arvalid && !m_axi_arready;
      if (aw_hs_q) check("awaddr", m_axi_awaddr, exp_addr);
      if (w_hs_q) begin check("wdata", m_axi_wdata, exp_wdata); check("wstrb", m_axi_wstrb, exp_wstrb); end
      if (ar_hs_q) check("araddr", m_axi_araddr, exp_addr);
    end
  end

  // One command end to end; timing predicted from channel delays (cycle 0 = acceptance)
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int a_d, input int w_d, input int r_d,
                         input logic [1:0] resp, input int hold);
    int n, acc, h, m, rsp_hs, exp_lat, exp_idle;
    bit to;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    ad = a_d; wd = w_d; bd = r_d; s_resp = resp; s_rdata = data;
    exp_addr = addr; exp_wdata = data; exp_wstrb = strb;
    if (wr) begin
      m = (a_d > w_d) ? 1 + a_d : 1 + w_d;
      h = m + 1 + r_d;
      to = (m >= TC) || (h > TC);
    end else begin
      m = 1 + a_d;
      h = m + 1 + r_d;
      to = (m >= TC) || (h > TC);
    end
    exp_lat   = to ? TC + 1 : h + 1;
    exp_resp  = to ? 2'b10 : resp;
    exp_rdata = (to || wr) ? 32'h0 : data;

    @(posedge ap_clk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wstrb = strb;
    cmd_wdata = wr ? data : $urandom;
    n = 0;
    @(negedge ap_clk);
    while (!cmd_ready && n < 200) begin @(negedge ap_clk); n++; end
    check("cmd_accept", cmd_ready, 1'b1);
    acc = cyc;
    @(posedge ap_clk); #1;
    cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom;

    n = 0;
    @(negedge ap_clk);
    while (!rsp_valid && n < 300) begin @(negedge ap_clk); n++; end
    check("rsp_seen", rsp_valid, 1'b1);
    check("rsp_latency", 64'(cyc - acc), 64'(exp_lat));
    check("rsp_timeout", rsp_timeout, to);
    check("rsp_resp", rsp_resp, exp_resp);
    check("rsp_rdata", rsp_rdata, exp_rdata);

    // A competing command while the response waits must not be taken
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hBAD0_0000;
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_resp", {rsp_timeout, rsp_resp}, {to, exp_resp});
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    @(posedge ap_clk); #1;
    rsp_ready = 1; cmd_valid = 0;
    @(negedge ap_clk);
    check("rsp_hs_valid", rsp_valid, 1'b1);
    rsp_hs = cyc - acc;
    @(posedge ap_clk); #1;
    rsp_ready = 0;

    exp_idle = to ? (((h > rsp_hs + 1) ? h : rsp_hs + 1) + 1) : rsp_hs + 1;
    n = 0;
    @(negedge ap_clk);
    while (!cmd_ready && n < 300) begin @(negedge ap_clk); n++; end
    check("idle_return", cmd_ready, 1'b1);
    check("idle_cycle", 64'(cyc - acc), 64'(exp_idle));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 0;
    @(negedge ap_clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
    check("rst_readies", {m_axi_bready, m_axi_rready}, 2'b00);

    run_txn(1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 0);
    run_txn(1, 32'h0000_2000, 32'hA5A5_0001, 4'h3, 3, 0, 0, 2'b01, 1);
    run_txn(0, 32'h0000_0008, 32'h1234_5678, 4'h0, 0, 0, 3, 2'b10, 0);
    run_txn(0, 32'h0000_000C, 32'hCAFE_F00D, 4'h0, 0, 0, 38, 2'b00, 0);
    run_txn(0, 32'h0000_0010, 32'h0BAD_CAFE, 4'h0, 0, 0, 14, 2'b11, 10);
    run_txn(1, 32'h0000_0014, 32'h1111_2222, 4'h5, 20, 2, 0, 2'b00, 2);
    run_txn(0, 32'h0000_0018, 32'h7777_8888, 4'h0, 5, 0, 10, 2'b01, 0);

    // Reset while the write address is still pending
    ad = 10; wd = 10; bd = 0;
    @(posedge ap_clk); #1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
    @(posedge ap_clk); #1;
    cmd_valid = 0;
    @(negedge ap_clk);
    check("pre_rst_awvalid", m_axi_awvalid, 1'b1);
    @(posedge ap_clk); #1 ap_rst = 1;
    @(posedge ap_clk); #1 ap_rst = 0;
    @(negedge ap_clk);
    check("mid_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      check("mid_rst_no_rsp", rsp_valid, 1'b0);
    end

    for (int k = 0; k < 60; k++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
              $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 22),
              2'($urandom), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
